branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 4; the maximum number of operand-wait cycles before a hazard timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 id_valid  input  1  the ID-stage instruction is valid this cycle.
REQ-005 br_op  input  3  branch opcode: 000 none, 001 beq, 010 bne, 011 bgt (A>B), 100 ble, 101 blt, 110 bge, 111 reserved.
REQ-006 opnd_ready  input  1  the comparator operands are final, with forwarding resolved.
REQ-007 cmp_result  input  2  comparator code: 10 A>B, 01 A==B, 00 A<B, 11 illegal.
REQ-008 pc_id  input  32  PC of the branch in ID.
REQ-009 imm16  input  16  signed word offset.
REQ-010 stall  output  1  freeze IF/ID; combinational.
REQ-011 redirect  output  1  registered one-cycle pulse that loads redirect_pc into the PC.
REQ-012 redirect_pc  output  32  registered branch target.
REQ-013 branch_cnt  output  16  count of resolved branches.
REQ-014 taken_cnt  output  16  count of taken branches.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 The block SHALL treat a cycle as a branch request when id_valid=1 and br_op!=000.
REQ-017 The state machine SHALL have three states: IDLE, WAIT and DONE.
REQ-018 IDLE transitions:
- Request with opnd_ready=1: resolve this cycle and go to DONE.
- Request with opnd_ready=0: go to WAIT with wait_cnt=1.
- Otherwise: stay in IDLE.
REQ-019 WAIT transitions:
- opnd_ready=1: resolve and go to DONE.
- opnd_ready=0 and wait_cnt<MAX_WAIT: increment wait_cnt and stay in WAIT.
- opnd_ready=0 and wait_cnt==MAX_WAIT: set err, resolve as not-taken and go to DONE.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; a new branch request arriving in DONE (branch in delay slot) SHALL set err and be ignored.
REQ-021 stall SHALL equal 1 when a request is present and opnd_ready=0 in IDLE, and throughout WAIT except the resolving cycle; stall SHALL be 0 in DONE.
REQ-022 Taken decision:
- beq: cmp==01.
- bne: cmp!=01.
- bgt: cmp==10.
- ble: cmp!=10.
- blt: cmp==00.
- bge: cmp!=00.
- br_op 111: not taken, err=1.
- cmp 11: not taken, err=1.
REQ-023 The target SHALL be pc_id + 4 + sign_extend(imm16)<<2, computed modulo 2^32 so that wrap-around is silent.
REQ-024 On resolve, redirect SHALL be 1 in the following cycle (DONE) only if the branch is taken; redirect_pc SHALL be loaded on every resolve.
REQ-025 In WAIT, pc_id and imm16 SHALL be latched on entry, and the latched values SHALL be used for the target.
REQ-026 On each resolve, branch_cnt SHALL increment by 1, and taken_cnt SHALL increment by 1 if the branch is taken; both counters SHALL saturate at 16'hFFFF.
REQ-027 Once set, err SHALL stay at 1 until reset.
REQ-028 Decision latency SHALL be one cycle from the resolve cycle to the redirect pulse; operand stalls add one cycle each.

Reset
REQ-029 When reset=0 at a clock edge, the block SHALL reset as follows:
- State goes to IDLE.
- wait_cnt, redirect, redirect_pc, branch_cnt, taken_cnt and err all go to 0.
REQ-030 While reset=0, stall SHALL be driven 0.
REQ-031 A reset in WAIT or DONE SHALL abort the branch with no redirect and no counter update.
REQ-032 The first request after reset is released SHALL be handled normally.

Verification
REQ-033 beq taken:
- Stimulus: pc_id=0x3000, imm16=0x0004, cmp=01, opnd_ready=1.
- Response: the next cycle has redirect=1 and redirect_pc=0x3014; branch_cnt=1, taken_cnt=1.
REQ-034 bne with equal operands:
- Stimulus: bne, cmp=01.
- Response: redirect=0, redirect_pc=target; branch_cnt increments and taken_cnt is unchanged.
REQ-035 Operand wait:
- Stimulus: blt with opnd_ready=0 for 2 cycles, then 1 with cmp=00; pc_id=0x4000 and imm16=0xFFFF latched.
- Response: stall=1 for 2 cycles, then redirect=1 with redirect_pc=0x4000.
REQ-036 Timeout:
- Stimulus: opnd_ready held at 0 with MAX_WAIT=4.
- Response: after 4 WAIT cycles, err=1, redirect=0 and the FSM is in DONE; it is in IDLE one cycle later.
REQ-037 Illegal inputs and delay-slot branch:
- Stimulus: cmp=11 or br_op=111, and separately a request issued in DONE.
- Response: err=1, no redirect, and the extra request is not counted.
REQ-038 Reset and saturation:
- Stimulus: reset=0 asserted during WAIT; separately, 65536 taken branches.
- Response: after the reset, all outputs are 0 and state is IDLE; after the branches, taken_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution FSM with operand-wait timeout, target generation and counters
// Resolves ID-stage branches, stalls on late operands, flags illegal or delay-slot cases.
module branch_ctrl #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [2:0]  br_op,
   input  logic        opnd_ready,
   input  logic [1:0]  cmp_result,
   input  logic [31:0] pc_id,
   input  logic [15:0] imm16,
   output logic        stall,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [15:0] branch_cnt,
   output logic [15:0] taken_cnt,
   output logic        err
);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

   state_t          state, state_nxt;
   logic [WCW-1:0]  wait_cnt, wait_cnt_nxt;
   logic [31:0]     lat_pc;
   logic [15:0]     lat_imm;
   logic [2:0]      lat_op;
   logic [15:0]     branch_q, taken_q, branch_nxt, taken_nxt;
   logic            req, resolve, timeout, latch, use_lat, err_set;
   logic            taken_raw, illegal, taken, err_nxt;
   logic [2:0]      op_sel;
   logic [31:0]     pc_sel, target;
   logic [15:0]     imm_sel;

   assign req         = id_valid && (br_op != 3'b000);
   assign branch_cnt  = branch_q;
   assign taken_cnt   = taken_q;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      resolve      = 1'b0;
      timeout      = 1'b0;
      latch        = 1'b0;
      use_lat      = 1'b0;
      err_set      = 1'b0;
      stall        = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (opnd_ready) begin
                  resolve   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  stall        = 1'b1;
                  latch        = 1'b1;
                  wait_cnt_nxt = WCW'(1);
                  state_nxt    = WAIT;
               end
            end
         end
         WAIT: begin
            use_lat = 1'b1;
            if (opnd_ready) begin
               resolve      = 1'b1;
               wait_cnt_nxt = '0;
               state_nxt    = DONE;
            end else if (wait_cnt < WMAX) begin
               stall        = 1'b1;
               wait_cnt_nxt = wait_cnt + 1'b1;
            end else begin
               timeout      = 1'b1;
               resolve      = 1'b1;
               wait_cnt_nxt = '0;
               state_nxt    = DONE;
            end
         end
         DONE: begin
            // A request here sits in the delay slot: flag it and drop it.
            err_set   = req;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!reset) stall = 1'b0;
   end

   assign op_sel  = use_lat ? lat_op  : br_op;
   assign pc_sel  = use_lat ? lat_pc  : pc_id;
   assign imm_sel = use_lat ? lat_imm : imm16;
   assign target  = pc_sel + 32'd4 + {{14{imm_sel[15]}}, imm_sel, 2'b00};

   always_comb begin
      case (op_sel)
         3'b001:  taken_raw = (cmp_result == 2'b01);
         3'b010:  taken_raw = (cmp_result != 2'b01);
         3'b011:  taken_raw = (cmp_result == 2'b10);
         3'b100:  taken_raw = (cmp_result != 2'b10);
         3'b101:  taken_raw = (cmp_result == 2'b00);
         3'b110:  taken_raw = (cmp_result != 2'b00);
         default: taken_raw = 1'b0;
      endcase
   end

   assign illegal = (op_sel == 3'b111) || (cmp_result == 2'b11);
   assign taken   = resolve && taken_raw && !illegal && !timeout;
   assign err_nxt = err || err_set || (resolve && (timeout || illegal));

   // Counters are rewritten every cycle so they always track their next-value logic.
   always_comb begin
      branch_nxt = branch_q;
      taken_nxt  = taken_q;
      if (resolve && branch_q != 16'hFFFF) branch_nxt = branch_q + 16'd1;
      if (taken && taken_q != 16'hFFFF)    taken_nxt  = taken_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         branch_q    <= '0;
         taken_q     <= '0;
         err         <= 1'b0;
         lat_pc      <= '0;
         lat_imm     <= '0;
         lat_op      <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         redirect <= taken;
         branch_q <= branch_nxt;
         taken_q  <= taken_nxt;
         err      <= err_nxt;
         if (resolve) redirect_pc <= target;
         if (latch) begin
            lat_pc  <= pc_id;
            lat_imm <= imm16;
            lat_op  <= br_op;
         end
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [2:0]  br_op;
   logic        opnd_ready;
   logic [1:0]  cmp_result;
   logic [31:0] pc_id;
   logic [15:0] imm16;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [15:0] branch_cnt;
   logic [15:0] taken_cnt;
   logic        err;
   logic [1:0]  st;
   int          checks = 0;
   int          failures = 0;

   branch_ctrl #(.MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .br_op(br_op),
      .opnd_ready(opnd_ready), .cmp_result(cmp_result), .pc_id(pc_id),
      .imm16(imm16), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
      .taken_cnt(taken_cnt), .err(err)
   );

   assign st = dut.state;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic rdy,
                        input logic [1:0] cmp, input logic [31:0] pc, input logic [15:0] imm);
      id_valid   = v;
      br_op      = op;
      opnd_ready = rdy;
      cmp_result = cmp;
      pc_id      = pc;
      imm16      = imm;
   endtask

   task automatic outs(input string tag, input logic rd, input logic [31:0] rpc,
                       input logic [15:0] bc, input logic [15:0] tc, input logic e);
      chk({tag, "_redirect"}, {31'd0, redirect}, {31'd0, rd});
      chk({tag, "_rpc"}, redirect_pc, rpc);
      chk({tag, "_branch_cnt"}, {16'd0, branch_cnt}, {16'd0, bc});
      chk({tag, "_taken_cnt"}, {16'd0, taken_cnt}, {16'd0, tc});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b1, 3'b001, 1'b0, 2'b01, 32'h0, 16'h0);
      @(negedge clk);
      @(negedge clk);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_state", {30'd0, st}, 32'd0);
      outs("reset", 1'b0, 32'h0, 16'd0, 16'd0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);

      // beq taken
      @(negedge clk);
      drive(1'b1, 3'b001, 1'b1, 2'b01, 32'h3000, 16'h0004);
      #1 chk("beq_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      outs("beq", 1'b1, 32'h3014, 16'd1, 16'd1, 1'b0);
      chk("beq_state_done", {30'd0, st}, 32'd2);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);
      chk("beq_pulse_end", {31'd0, redirect}, 32'd0);
      chk("beq_state_idle", {30'd0, st}, 32'd0);

      // bne with equal operands: not taken
      drive(1'b1, 3'b010, 1'b1, 2'b01, 32'h0000_0100, 16'h0010);
      @(negedge clk);
      outs("bne_eq", 1'b0, 32'h144, 16'd2, 16'd1, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);

      // bgt with A>B: taken
      drive(1'b1, 3'b011, 1'b1, 2'b10, 32'h0000_0200, 16'h0000);
      @(negedge clk);
      outs("bgt", 1'b1, 32'h204, 16'd3, 16'd2, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);

      // blt with two operand-wait cycles; target from latched pc/imm
      drive(1'b1, 3'b101, 1'b0, 2'b00, 32'h4000, 16'hFFFF);
      #1 chk("wait_stall1", {31'd0, stall}, 32'd1);
      @(negedge clk);
      drive(1'b1, 3'b101, 1'b0, 2'b00, 32'h9999_0000, 16'h1234);
      #1 chk("wait_stall2", {31'd0, stall}, 32'd1);
      @(negedge clk);
      drive(1'b1, 3'b101, 1'b1, 2'b00, 32'h9999_0000, 16'h1234);
      #1 chk("wait_resolve_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      outs("wait_blt", 1'b1, 32'h4000, 16'd4, 16'd3, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);

      // target wrap-around modulo 2^32
      drive(1'b1, 3'b001, 1'b1, 2'b01, 32'hFFFF_FFF0, 16'h0010);
      @(negedge clk);
      outs("wrap", 1'b1, 32'h34, 16'd5, 16'd4, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);

      // operand timeout after MAX_WAIT wait cycles
      drive(1'b1, 3'b001, 1'b0, 2'b01, 32'h500, 16'h0001);
      @(negedge clk);
      chk("to_state_wait", {30'd0, st}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         #1 chk("to_stall", {31'd0, stall}, 32'd1);
         @(negedge clk);
      end
      #1 chk("to_last_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("to_state_done", {30'd0, st}, 32'd2);
      outs("timeout", 1'b0, 32'h508, 16'd6, 16'd4, 1'b1);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      @(negedge clk);
      chk("to_state_idle", {30'd0, st}, 32'd0);

      // reset during WAIT aborts the branch
      drive(1'b1, 3'b001, 1'b0, 2'b01, 32'h800, 16'h0002);
      @(negedge clk);
      chk("rw_state_wait", {30'd0, st}, 32'd1);
      reset = 1'b0;
      drive(1'b1, 3'b001, 1'b1, 2'b01, 32'h800, 16'h0002);
      #1 chk("rw_stall_in_reset", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("rw_state", {30'd0, st}, 32'd0);
      outs("rst_wait", 1'b0, 32'h0, 16'd0, 16'd0, 1'b0);
      reset = 1'b1;
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);

      // illegal comparator code
      @(negedge clk);
      drive(1'b1, 3'b001, 1'b1, 2'b11, 32'h600, 16'h0000);
      @(negedge clk);
      outs("cmp11", 1'b0, 32'h604, 16'd1, 16'd0, 1'b1);
      do_reset();

      // reserved opcode
      @(negedge clk);
      drive(1'b1, 3'b111, 1'b1, 2'b01, 32'h600, 16'h0001);
      @(negedge clk);
      outs("op111", 1'b0, 32'h608, 16'd1, 16'd0, 1'b1);
      do_reset();

      // first request after reset, then a delay-slot request in DONE
      @(negedge clk);
      drive(1'b1, 3'b001, 1'b1, 2'b01, 32'h700, 16'h0000);
      @(negedge clk);
      outs("ds_first", 1'b1, 32'h704, 16'd1, 16'd1, 1'b0);
      drive(1'b1, 3'b001, 1'b1, 2'b01, 32'h900, 16'h0000);
      @(negedge clk);
      drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
      outs("ds_slot", 1'b0, 32'h704, 16'd1, 16'd1, 1'b1);
      chk("ds_state", {30'd0, st}, 32'd0);
      do_reset();

      // counter saturation, preloaded close to the limit
      @(negedge clk);
      force dut.branch_q = 16'hFFFD;
      force dut.taken_q  = 16'hFFFD;
      @(negedge clk);
      release dut.branch_q;
      release dut.taken_q;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'b110, 1'b1, 2'b10, 32'hA00, 16'h0000);
         @(negedge clk);
         chk("sat_taken_cnt", {16'd0, taken_cnt}, (i == 0) ? 32'hFFFE : 32'hFFFF);
         chk("sat_branch_cnt", {16'd0, branch_cnt}, (i == 0) ? 32'hFFFE : 32'hFFFF);
         chk("sat_redirect", {31'd0, redirect}, 32'd1);
         drive(1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 16'h0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
